cache_port_arbiter: RTL and testbench
=====================================

Name: cache_port_arbiter

Overview:
Two-requester arbiter that shares the single processor-side port of the `cache` block between port 0 and port 1 (e.g. instruction fetch and data access).
- Each request is latched and forwarded to the cache as a level request.
- The request is held until the cache's matching ready.
- Completion is returned to the owning requester as a one-cycle done pulse.
- Round-robin fairness; one transaction outstanding at a time.

Parameters:
ADDR_W, 10, address width (matches cache proc_address)
DATA_W, 8, write data width
LINE_W, 32, read data width
TIMEOUT_CYCLES, 64, watchdog limit (used only with CACHE_ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
r0_rd_req  input  1  port 0 read request (level, held until r0_rd_done)
r0_wr_req  input  1  port 0 write request (level, held until r0_wr_done)
r0_addr  input  ADDR_W  port 0 address, stable while a request is high
r0_wdata  input  DATA_W  port 0 write data
r0_rd_data  output  LINE_W  port 0 read result
r0_rd_done  output  1  port 0 read complete, 1-cycle pulse
r0_wr_done  output  1  port 0 write complete, 1-cycle pulse
r1_rd_req, r1_wr_req, r1_addr, r1_wdata, r1_rd_data, r1_rd_done, r1_wr_done: same as port 0, for port 1
proc_read_req  output  1  to cache
proc_write_req  output  1  to cache
proc_address  output  ADDR_W  to cache
proc_write_data  output  DATA_W  to cache
cache_read_data  input  LINE_W  from cache
cache_read_ready  input  1  from cache
cache_write_ready  input  1  from cache
arb_timeout  output  1  watchdog abort pulse (constant 0 without CACHE_ARB_TIMEOUT_EN)

Behaviour:
- Reset (async, any state, including mid-transaction):
  - state=IDLE; last_grant=1, so port 0 wins the first tie.
  - All outputs 0, including rN_rd_data.
  - The aborted transaction produces no done pulse.
- FSM states: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - pendN = rN_rd_req | rN_wr_req.
  - Only one port pending: grant it.
  - Both pending: grant the port != last_grant.
  - On grant, latch port id, op, addr and wdata, update last_grant, go BUSY.
  - Same port with both rd and wr high: read wins; the write stays pending and is served by a later grant.
- BUSY:
  - Drive proc_read_req or proc_write_req (registered, exactly one high) with the latched proc_address/proc_write_data.
  - Hold all of these constant until the matching ready is sampled high at a clock edge.
  - Read: on cache_read_ready=1, capture cache_read_data into the granted port's rN_rd_data, deassert the request, go RESP.
  - Write: on cache_write_ready=1, deassert the request, go RESP.
  - The non-matching ready is ignored.
- RESP:
  - Pulse the granted port's rd_done or wr_done for exactly this cycle.
  - proc_*_req are low.
  - Next state IDLE.
- Requester contract: hold req, addr and wdata until done is seen; drop req at the edge ending the done cycle.
  - The arbiter never samples requests in RESP, so a single request is never served twice.
- Ready outside BUSY: ignored.
- Latency:
  - Request sampled at edge 0; proc_*_req high from edge 1.
  - Ready sampled high at edge k (k>=2) -> done high during cycle k..k+1.
  - Minimum request-to-done latency: 3 cycles.
- rN_rd_data: updated only by a completed read for port N; otherwise holds its value.
- Non-granted port: its requests wait with no side effects.
  - Starvation-free: with both ports saturated, grants strictly alternate.

Optional Feature:
CACHE_ARB_TIMEOUT_EN:
- When defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without the matching ready, deassert proc_*_req and go RESP.
  - In RESP, pulse the granted port's done together with arb_timeout for 1 cycle.
  - rN_rd_data is not updated.
- When undefined: no counter is built, BUSY waits indefinitely, and arb_timeout is tied 0.

Test Plan:
- Reset then single write: r0_wr_req=1, r0_addr=10'h001, r0_wdata=8'hFF, cache_write_ready asserted 2 cycles after proc_write_req -> proc_address=001, proc_write_data=FF held until ready; r0_wr_done pulses once; proc_write_req low in RESP.
- Single read: r1_rd_req at 10'h001, cache returns 32'hDEADBEEF with cache_read_ready -> r1_rd_data=DEADBEEF with r1_rd_done pulse; r0_rd_data unchanged (0).
- Simultaneous requests after reset: r0 read and r1 write both high -> port 0 served first, then port 1; with both held continuously over 4 transactions, grants alternate 0,1,0,1.
- Wrong ready: during a read, pulse cache_write_ready -> ignored and state stays BUSY; a later cache_read_ready completes the read.
- Async rst asserted mid-BUSY -> proc_*_req drop immediately, no done pulse; after release, a fresh r1 request is granted normally.
- With CACHE_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, a read never acknowledged -> after 8 BUSY cycles: r0_rd_done and arb_timeout pulse together, r0_rd_data unchanged.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter
//   Shares the single processor-side port of the cache between two
//   requesters (port 0 and port 1) with round-robin fairness and one
//   transaction outstanding at a time.
//
//   Ports
//     clk, rst                    clock, asynchronous active-high reset
//     rN_rd_req / rN_wr_req       level requests from port N (held until done)
//     rN_addr / rN_wdata          port N address and write data
//     rN_rd_data                  last read line returned to port N
//     rN_rd_done / rN_wr_done     one-cycle completion pulses to port N
//     proc_read_req/write_req     level requests to the cache (registered)
//     proc_address/write_data     latched address / data to the cache
//     cache_read_data/ready       read response from the cache
//     cache_write_ready           write acknowledge from the cache
//     arb_timeout                 watchdog abort pulse
//
//   Optional feature: define CACHE_ARB_TIMEOUT_EN to build a watchdog that
//   aborts a BUSY transaction after TIMEOUT_CYCLES cycles without ready.
//   Without it, BUSY waits indefinitely and arb_timeout is tied low.
module cache_port_arbiter #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 8,
  parameter int LINE_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_rd_req,
  input  logic              r0_wr_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic [LINE_W-1:0] r0_rd_data,
  output logic              r0_rd_done,
  output logic              r0_wr_done,
  input  logic              r1_rd_req,
  input  logic              r1_wr_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic [LINE_W-1:0] r1_rd_data,
  output logic              r1_rd_done,
  output logic              r1_wr_done,
  output logic              proc_read_req,
  output logic              proc_write_req,
  output logic [ADDR_W-1:0] proc_address,
  output logic [DATA_W-1:0] proc_write_data,
  input  logic [LINE_W-1:0] cache_read_data,
  input  logic              cache_read_ready,
  input  logic              cache_write_ready,
  output logic              arb_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                gnt_port_q, gnt_port_d;   // 0: port 0, 1: port 1
  logic                gnt_wr_q, gnt_wr_d;       // 0: read, 1: write
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_req_q, rd_req_d;
  logic                wr_req_q, wr_req_d;
  logic [LINE_W-1:0]   r0_rd_data_q, r0_rd_data_d;
  logic [LINE_W-1:0]   r1_rd_data_q, r1_rd_data_d;
  logic                r0_rd_done_q, r0_rd_done_d;
  logic                r0_wr_done_q, r0_wr_done_d;
  logic                r1_rd_done_q, r1_rd_done_d;
  logic                r1_wr_done_q, r1_wr_done_d;

  logic                pend0, pend1, pick;
  logic                finish;

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic                expire;
  // The TIMEOUT_CYCLES-th BUSY cycle is the one that sees cnt == limit-1.
  assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  assign pend0 = r0_rd_req | r0_wr_req;
  assign pend1 = r1_rd_req | r1_wr_req;
  // Port 1 wins when it is alone, or when both pend and port 0 had the last grant.
  assign pick  = pend1 & (~pend0 | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_port_d   = gnt_port_q;
    gnt_wr_d     = gnt_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_req_d     = rd_req_q;
    wr_req_d     = wr_req_q;
    r0_rd_data_d = r0_rd_data_q;
    r1_rd_data_d = r1_rd_data_q;
    finish       = 1'b0;
`ifdef CACHE_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pend0 | pend1) begin
          gnt_port_d   = pick;
          // Read has priority when a port raises both; its write stays pending.
          gnt_wr_d     = pick ? ~r1_rd_req : ~r0_rd_req;
          addr_d       = pick ? r1_addr  : r0_addr;
          wdata_d      = pick ? r1_wdata : r0_wdata;
          last_grant_d = pick;
          state_d      = BUSY;
`ifdef CACHE_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end

      BUSY: begin
        // First BUSY cycle issues the registered request; ready is only
        // honoured once the matching request is visible to the cache.
        if (!(rd_req_q | wr_req_q)) begin
          rd_req_d = ~gnt_wr_q;
          wr_req_d = gnt_wr_q;
        end else if (rd_req_q && cache_read_ready) begin
          if (gnt_port_q) r1_rd_data_d = cache_read_data;
          else            r0_rd_data_d = cache_read_data;
          rd_req_d = 1'b0;
          finish   = 1'b1;
          state_d  = RESP;
        end else if (wr_req_q && cache_write_ready) begin
          wr_req_d = 1'b0;
          finish   = 1'b1;
          state_d  = RESP;
        end
`ifdef CACHE_ARB_TIMEOUT_EN
        if (state_d == BUSY) begin
          if (expire) begin
            rd_req_d  = 1'b0;
            wr_req_d  = 1'b0;
            finish    = 1'b1;
            timeout_d = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
      end
    endcase

    r0_rd_done_d = finish & ~gnt_port_q & ~gnt_wr_q;
    r0_wr_done_d = finish & ~gnt_port_q &  gnt_wr_q;
    r1_rd_done_d = finish &  gnt_port_q & ~gnt_wr_q;
    r1_wr_done_d = finish &  gnt_port_q &  gnt_wr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_port_q   <= 1'b0;
      gnt_wr_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      r0_rd_data_q <= '0;
      r1_rd_data_q <= '0;
      r0_rd_done_q <= 1'b0;
      r0_wr_done_q <= 1'b0;
      r1_rd_done_q <= 1'b0;
      r1_wr_done_q <= 1'b0;
`ifdef CACHE_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_port_q   <= gnt_port_d;
      gnt_wr_q     <= gnt_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_req_q     <= rd_req_d;
      wr_req_q     <= wr_req_d;
      r0_rd_data_q <= r0_rd_data_d;
      r1_rd_data_q <= r1_rd_data_d;
      r0_rd_done_q <= r0_rd_done_d;
      r0_wr_done_q <= r0_wr_done_d;
      r1_rd_done_q <= r1_rd_done_d;
      r1_wr_done_q <= r1_wr_done_d;
`ifdef CACHE_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign proc_read_req   = rd_req_q;
  assign proc_write_req  = wr_req_q;
  assign proc_address    = addr_q;
  assign proc_write_data = wdata_q;
  assign r0_rd_data      = r0_rd_data_q;
  assign r1_rd_data      = r1_rd_data_q;
  assign r0_rd_done      = r0_rd_done_q;
  assign r0_wr_done      = r0_wr_done_q;
  assign r1_rd_done      = r1_rd_done_q;
  assign r1_wr_done      = r1_wr_done_q;
`ifdef CACHE_ARB_TIMEOUT_EN
  assign arb_timeout     = timeout_q;
`else
  assign arb_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: a cycle-by-cycle vector table
// for single write / single read / ignored readies, plus hand-written
// sequences for fairness, same-port read+write, async reset and watchdog.
module tb_cache_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_rd_req, r0_wr_req, r1_rd_req, r1_wr_req;
  logic [9:0]  r0_addr, r1_addr;
  logic [7:0]  r0_wdata, r1_wdata;
  logic [31:0] r0_rd_data, r1_rd_data;
  logic        r0_rd_done, r0_wr_done, r1_rd_done, r1_wr_done;
  logic        proc_read_req, proc_write_req;
  logic [9:0]  proc_address;
  logic [7:0]  proc_write_data;
  logic [31:0] cache_read_data;
  logic        cache_read_ready, cache_write_ready;
  logic        arb_timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_port_arbiter #(
    .ADDR_W(10), .DATA_W(8), .LINE_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .r0_rd_req(r0_rd_req), .r0_wr_req(r0_wr_req), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rd_data(r0_rd_data), .r0_rd_done(r0_rd_done),
    .r0_wr_done(r0_wr_done),
    .r1_rd_req(r1_rd_req), .r1_wr_req(r1_wr_req), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rd_data(r1_rd_data), .r1_rd_done(r1_rd_done),
    .r1_wr_done(r1_wr_done),
    .proc_read_req(proc_read_req), .proc_write_req(proc_write_req),
    .proc_address(proc_address), .proc_write_data(proc_write_data),
    .cache_read_data(cache_read_data), .cache_read_ready(cache_read_ready),
    .cache_write_ready(cache_write_ready), .arb_timeout(arb_timeout)
  );

  typedef struct {
    logic        r0_rd, r0_wr, r1_rd, r1_wr, crd, cwr;
    logic [31:0] cdata;
    logic        e_prd, e_pwr;
    logic [9:0]  e_addr;
    logic [7:0]  e_wdata;
    logic [3:0]  e_done;   // {r1_wr, r1_rd, r0_wr, r0_rd}
    logic [31:0] e_d0, e_d1;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [5:0] ins, input logic [31:0] cdata,
                              input logic [1:0] preq, input logic [9:0] addr,
                              input logic [7:0] wdata, input logic [3:0] done,
                              input logic [31:0] d0, input logic [31:0] d1);
    vec_t v;
    {v.r0_rd, v.r0_wr, v.r1_rd, v.r1_wr, v.crd, v.cwr} = ins;
    v.cdata   = cdata;
    {v.e_prd, v.e_pwr} = preq;
    v.e_addr  = addr;
    v.e_wdata = wdata;
    v.e_done  = done;
    v.e_d0    = d0;
    v.e_d1    = d1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] dones();
    return {r1_wr_done, r1_rd_done, r0_wr_done, r0_rd_done};
  endfunction

  // Waits for the issued request, checks it, acknowledges it and checks the
  // resulting done pulse. Returns at the negedge inside the done cycle.
  task automatic serve(input int port, input logic is_wr, input logic [9:0] exp_addr,
                       input logic [7:0] exp_wdata, input logic [31:0] rdata);
    int n;
    logic [3:0] exp_done;
    n = 0;
    while (!(proc_read_req || proc_write_req) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("issue_wait", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    check("issue_op", {31'd0, proc_write_req}, {31'd0, is_wr});
    check("issue_addr", {22'd0, proc_address}, {22'd0, exp_addr});
    if (is_wr) check("issue_wdata", {24'd0, proc_write_data}, {24'd0, exp_wdata});
    @(negedge clk);
    if (is_wr) cache_write_ready = 1'b1;
    else begin
      cache_read_ready = 1'b1;
      cache_read_data  = rdata;
    end
    @(posedge clk); #1;
    exp_done = is_wr ? ((port == 1) ? 4'b1000 : 4'b0010)
                     : ((port == 1) ? 4'b0100 : 4'b0001);
    check("done_flags", {28'd0, dones()}, {28'd0, exp_done});
    check("resp_req_low", {30'd0, proc_read_req, proc_write_req}, 32'd0);
    if (!is_wr) check("rd_data", (port == 1) ? r1_rd_data : r0_rd_data, rdata);
    @(negedge clk);
    cache_read_ready  = 1'b0;
    cache_write_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_preq"}, {30'd0, proc_read_req, proc_write_req}, 32'd0);
    check({tag, "_dones"}, {28'd0, dones()}, 32'd0);
    check({tag, "_d0"}, r0_rd_data, 32'd0);
    check({tag, "_d1"}, r1_rd_data, 32'd0);
    check({tag, "_addr"}, {22'd0, proc_address}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    {r0_rd_req, r0_wr_req, r1_rd_req, r1_wr_req} = '0;
    r0_addr = 10'h001; r0_wdata = 8'hFF;
    r1_addr = 10'h001; r1_wdata = 8'h00;
    cache_read_data = '0; cache_read_ready = 1'b0; cache_write_ready = 1'b0;

    // ins = {r0_rd, r0_wr, r1_rd, r1_wr, crd, cwr}; preq = {prd, pwr}
    vecs[0]  = mk(6'b010000, 32'h0,        2'b00, 10'h001, 8'hFF, 4'b0000, 32'h0, 32'h0);
    vecs[1]  = mk(6'b010000, 32'h0,        2'b01, 10'h001, 8'hFF, 4'b0000, 32'h0, 32'h0);
    vecs[2]  = mk(6'b010000, 32'h0,        2'b01, 10'h001, 8'hFF, 4'b0000, 32'h0, 32'h0);
    vecs[3]  = mk(6'b010001, 32'h0,        2'b00, 10'h001, 8'hFF, 4'b0010, 32'h0, 32'h0);
    vecs[4]  = mk(6'b000000, 32'h0,        2'b00, 10'h001, 8'hFF, 4'b0000, 32'h0, 32'h0);
    vecs[5]  = mk(6'b001000, 32'h0,        2'b00, 10'h001, 8'h00, 4'b0000, 32'h0, 32'h0);
    vecs[6]  = mk(6'b001000, 32'h0,        2'b10, 10'h001, 8'h00, 4'b0000, 32'h0, 32'h0);
    vecs[7]  = mk(6'b001010, 32'hDEADBEEF, 2'b00, 10'h001, 8'h00, 4'b0100, 32'h0, 32'hDEADBEEF);
    vecs[8]  = mk(6'b000000, 32'h0,        2'b00, 10'h001, 8'h00, 4'b0000, 32'h0, 32'hDEADBEEF);
    vecs[9]  = mk(6'b000010, 32'h12345678, 2'b00, 10'h001, 8'h00, 4'b0000, 32'h0, 32'hDEADBEEF);
    vecs[10] = mk(6'b100000, 32'h0,        2'b00, 10'h001, 8'hFF, 4'b0000, 32'h0, 32'hDEADBEEF);
    vecs[11] = mk(6'b100000, 32'h0,        2'b10, 10'h001, 8'hFF, 4'b0000, 32'h0, 32'hDEADBEEF);
    vecs[12] = mk(6'b100001, 32'h0,        2'b10, 10'h001, 8'hFF, 4'b0000, 32'h0, 32'hDEADBEEF);
    vecs[13] = mk(6'b100010, 32'hA5A5A5A5, 2'b00, 10'h001, 8'hFF, 4'b0001, 32'hA5A5A5A5, 32'hDEADBEEF);
    vecs[14] = mk(6'b000000, 32'h0,        2'b00, 10'h001, 8'hFF, 4'b0000, 32'hA5A5A5A5, 32'hDEADBEEF);

    // Reset state
    @(posedge clk); #1;
    check_reset_outputs("reset");
    check("reset_timeout", {31'd0, arb_timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: single write, single read, ready outside BUSY, wrong ready
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      {r0_rd_req, r0_wr_req, r1_rd_req, r1_wr_req} =
        {vecs[i].r0_rd, vecs[i].r0_wr, vecs[i].r1_rd, vecs[i].r1_wr};
      cache_read_ready  = vecs[i].crd;
      cache_write_ready = vecs[i].cwr;
      cache_read_data   = vecs[i].cdata;
      @(posedge clk); #1;
      check($sformatf("v%0d_preq", i), {30'd0, proc_read_req, proc_write_req},
            {30'd0, vecs[i].e_prd, vecs[i].e_pwr});
      check($sformatf("v%0d_addr", i), {22'd0, proc_address}, {22'd0, vecs[i].e_addr});
      check($sformatf("v%0d_wdata", i), {24'd0, proc_write_data}, {24'd0, vecs[i].e_wdata});
      check($sformatf("v%0d_done", i), {28'd0, dones()}, {28'd0, vecs[i].e_done});
      check($sformatf("v%0d_d0", i), r0_rd_data, vecs[i].e_d0);
      check($sformatf("v%0d_d1", i), r1_rd_data, vecs[i].e_d1);
      check($sformatf("v%0d_tmo", i), {31'd0, arb_timeout}, 32'd0);
    end
    @(negedge clk);
    {r0_rd_req, r0_wr_req, r1_rd_req, r1_wr_req} = '0;
    cache_read_ready = 1'b0; cache_write_ready = 1'b0;

    // Fresh reset, then both ports saturated: grants must go 0,1,0,1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    r0_addr = 10'h100; r1_addr = 10'h200; r1_wdata = 8'h5A;
    r0_rd_req = 1'b1; r1_wr_req = 1'b1;
    serve(0, 1'b0, 10'h100, 8'h00, 32'h11111111);
    serve(1, 1'b1, 10'h200, 8'h5A, 32'h0);
    serve(0, 1'b0, 10'h100, 8'h00, 32'h22222222);
    serve(1, 1'b1, 10'h200, 8'h5A, 32'h0);
    r0_rd_req = 1'b0; r1_wr_req = 1'b0;

    // Same port raises read and write: read first, write afterwards
    r0_addr = 10'h0F0; r0_wdata = 8'h3C;
    r0_rd_req = 1'b1; r0_wr_req = 1'b1;
    serve(0, 1'b0, 10'h0F0, 8'h00, 32'h33333333);
    r0_rd_req = 1'b0;
    serve(0, 1'b1, 10'h0F0, 8'h3C, 32'h0);
    r0_wr_req = 1'b0;
    check("r1_data_kept", r1_rd_data, 32'h0);

    // Async reset in the middle of BUSY
    r0_addr = 10'h0AA; r0_wdata = 8'h77; r0_wr_req = 1'b1;
    begin
      int n;
      n = 0;
      while (!proc_write_req && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("rst_issue_wait", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    r0_wr_req = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("held_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_quiet%0d", i),
            {26'd0, dones(), proc_read_req, proc_write_req}, 32'd0);
    end
    @(negedge clk);
    r1_addr = 10'h155; r1_rd_req = 1'b1;
    serve(1, 1'b0, 10'h155, 8'h00, 32'hCAFEF00D);
    r1_rd_req = 1'b0;
    check("post_rst_d0", r0_rd_data, 32'h0);

`ifdef CACHE_ARB_TIMEOUT_EN
    // Read never acknowledged: watchdog aborts after 8 BUSY cycles
    begin
      int n;
      @(negedge clk);
      r0_addr = 10'h3FF; r0_rd_req = 1'b1;
      @(posedge clk); #1;   // grant edge
      n = 0;
      while (!r0_rd_done && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      check("tmo_edges", n, 32'd8);
      check("tmo_pulse", {30'd0, arb_timeout, r0_rd_done}, 32'd3);
      check("tmo_d0", r0_rd_data, 32'h0);
      check("tmo_req_low", {30'd0, proc_read_req, proc_write_req}, 32'd0);
      @(negedge clk);
      r0_rd_req = 1'b0;
      @(posedge clk); #1;
      check("tmo_pulse_end", {30'd0, arb_timeout, r0_rd_done}, 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
